// File: rtl/processor_pkg.sv
// Shared constants for the single-cycle RV32I-subset processor: opcodes, ALU op codes
// and branch funct3 values.
package processor_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  typedef enum logic [3:0] {
    AluAdd   = 4'b0000,
    AluSll   = 4'b0001,
    AluSlt   = 4'b0010,
    AluSltu  = 4'b0011,
    AluXor   = 4'b0100,
    AluSrl   = 4'b0101,
    AluOr    = 4'b0110,
    AluAnd   = 4'b0111,
    AluSub   = 4'b1000,
    AluSra   = 4'b1101,
    AluPassB = 4'b1111
  } alu_op_e;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;
  localparam logic [2:0] F3Sr   = 3'b101;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/processor_regfile.sv
// 31-entry register file with two combinational read ports and one write port;
// x0 is hardwired to zero and all registers clear on asynchronous reset.
module processor_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [31:0] r_regs [1:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/processor.sv
// Single-cycle RV32I-subset core: inline decode, ALU and comparator, commit gated by toggle.
// Define PROCESSOR_DMEM_EN to instantiate the 64-word data memory (otherwise loads read 0).
module processor
  import processor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        toggle,
  input  logic [31:0] Instr,
  output logic [6:0]  pcOPcode,
  output logic [4:0]  pcrs1,
  output logic [4:0]  pcrs2,
  output logic [4:0]  pcrd,
  output logic [31:0] pcImm_OUT,
  output logic [3:0]  pcALUop,
  output logic [31:0] P_out,
  output logic        BrEQ,
  output logic        BrLt,
  output logic        preg_write,
  output logic        pImmSel,
  output logic        BSeL,
  output logic        ASeL,
  output logic        BrUN,
  output logic        MemRw,
  output logic        WBSeL
);

  logic [31:0] r_pc;
  logic [31:0] w_rs1_data, w_rs2_data, w_a, w_b, w_alu, w_load_data;
  logic [31:0] w_pc_plus4, w_pc_next;
  logic [2:0]  w_funct3;
  logic [3:0]  w_alu_op;
  logic        w_legal, w_is_branch, w_is_jal, w_is_jalr, w_taken;

  assign pcOPcode   = Instr[6:0];
  assign pcrs1      = Instr[19:15];
  assign pcrs2      = Instr[24:20];
  assign pcrd       = Instr[11:7];
  assign w_funct3   = Instr[14:12];
  assign pcALUop    = w_alu_op;
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    preg_write  = 1'b0;
    pImmSel     = 1'b0;
    BSeL        = 1'b0;
    ASeL        = 1'b0;
    BrUN        = 1'b0;
    MemRw       = 1'b0;
    WBSeL       = 1'b0;
    w_alu_op    = AluAdd;
    pcImm_OUT   = '0;
    w_legal     = 1'b1;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    case (Instr[6:0])
      OpcOp: begin
        preg_write = 1'b1;
        w_alu_op   = {Instr[30], w_funct3};
      end
      OpcOpImm: begin
        {preg_write, pImmSel, BSeL} = 3'b111;
        pcImm_OUT = sext12(Instr[31:20]);
        w_alu_op  = (w_funct3 == F3Sr && Instr[30]) ? AluSra : {1'b0, w_funct3};
      end
      OpcLoad: begin
        {preg_write, pImmSel, BSeL, WBSeL} = 4'b1111;
        pcImm_OUT = sext12(Instr[31:20]);
      end
      OpcStore: begin
        {pImmSel, BSeL, MemRw} = 3'b111;
        pcImm_OUT = sext12({Instr[31:25], Instr[11:7]});
      end
      OpcBranch: begin
        {pImmSel, BSeL, ASeL} = 3'b111;
        BrUN        = (w_funct3 == F3Bltu) || (w_funct3 == F3Bgeu);
        w_is_branch = 1'b1;
        pcImm_OUT   = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      end
      OpcLui: begin
        {preg_write, pImmSel, BSeL} = 3'b111;
        w_alu_op  = AluPassB;
        pcImm_OUT = {Instr[31:12], 12'b0};
      end
      OpcAuipc: begin
        {preg_write, pImmSel, BSeL, ASeL} = 4'b1111;
        pcImm_OUT = {Instr[31:12], 12'b0};
      end
      OpcJal: begin
        {preg_write, pImmSel, BSeL, ASeL} = 4'b1111;
        w_is_jal  = 1'b1;
        pcImm_OUT = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      end
      OpcJalr: begin
        {preg_write, pImmSel, BSeL} = 3'b111;
        w_is_jalr = 1'b1;
        pcImm_OUT = sext12(Instr[31:20]);
      end
      default: w_legal = 1'b0;
    endcase
  end

  processor_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (toggle & preg_write),
    .i_waddr  (Instr[11:7]),
    .i_wdata  (P_out),
    .i_raddr1 (Instr[19:15]),
    .i_raddr2 (Instr[24:20]),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

  // Comparator outputs are masked on illegal opcodes so every strobe reads 0 there.
  assign BrEQ = w_legal && (w_rs1_data == w_rs2_data);
  assign BrLt = w_legal && (BrUN ? (w_rs1_data < w_rs2_data)
                                 : ($signed(w_rs1_data) < $signed(w_rs2_data)));

  assign w_a = ASeL ? r_pc : w_rs1_data;
  assign w_b = BSeL ? pcImm_OUT : w_rs2_data;

  always_comb begin
    case (w_alu_op)
      AluAdd:   w_alu = w_a + w_b;
      AluSub:   w_alu = w_a - w_b;
      AluSll:   w_alu = w_a << w_b[4:0];
      AluSlt:   w_alu = {31'b0, $signed(w_a) < $signed(w_b)};
      AluSltu:  w_alu = {31'b0, w_a < w_b};
      AluXor:   w_alu = w_a ^ w_b;
      AluSrl:   w_alu = w_a >> w_b[4:0];
      AluSra:   w_alu = $unsigned($signed(w_a) >>> w_b[4:0]);
      AluOr:    w_alu = w_a | w_b;
      AluAnd:   w_alu = w_a & w_b;
      AluPassB: w_alu = w_b;
      default:  w_alu = '0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    if (w_is_branch) begin
      case (w_funct3)
        F3Beq:          w_taken = BrEQ;
        F3Bne:          w_taken = !BrEQ;
        F3Blt, F3Bltu:  w_taken = BrLt;
        F3Bge, F3Bgeu:  w_taken = !BrLt;
        default:        w_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    if (w_is_jal || w_is_jalr) begin
      P_out = w_pc_plus4;
    end else if (WBSeL) begin
      P_out = w_load_data;
    end else begin
      P_out = w_alu;
    end
  end

  always_comb begin
    if (w_is_jal || w_taken) begin
      w_pc_next = w_alu;
    end else if (w_is_jalr) begin
      w_pc_next = {w_alu[31:1], 1'b0};
    end else begin
      w_pc_next = w_pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (toggle) begin
      r_pc <= w_pc_next;
    end
  end

`ifdef PROCESSOR_DMEM_EN
  logic [31:0] r_dmem [64];
  logic [5:0]  w_dmem_addr;

  assign w_dmem_addr = w_alu[7:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        r_dmem[i] <= '0;
      end
    end else if (toggle && MemRw) begin
      r_dmem[w_dmem_addr] <= w_rs2_data;
    end
  end

  assign w_load_data = r_dmem[w_dmem_addr];
`else
  assign w_load_data = '0;
`endif

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed scenarios plus random instructions
// checked against an instruction-level reference model.
module tb_processor;

  logic        clk;
  logic        rst_n;
  logic        toggle;
  logic [31:0] Instr;
  logic [6:0]  pcOPcode;
  logic [4:0]  pcrs1, pcrs2, pcrd;
  logic [31:0] pcImm_OUT, P_out;
  logic [3:0]  pcALUop;
  logic        BrEQ, BrLt, preg_write, pImmSel, BSeL, ASeL, BrUN, MemRw, WBSeL;

  processor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .toggle     (toggle),
    .Instr      (Instr),
    .pcOPcode   (pcOPcode),
    .pcrs1      (pcrs1),
    .pcrs2      (pcrs2),
    .pcrd       (pcrd),
    .pcImm_OUT  (pcImm_OUT),
    .pcALUop    (pcALUop),
    .P_out      (P_out),
    .BrEQ       (BrEQ),
    .BrLt       (BrLt),
    .preg_write (preg_write),
    .pImmSel    (pImmSel),
    .BSeL       (BSeL),
    .ASeL       (ASeL),
    .BrUN       (BrUN),
    .MemRw      (MemRw),
    .WBSeL      (WBSeL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [98:0] w_obs;
  assign w_obs = {pcOPcode, pcrs1, pcrs2, pcrd, pcImm_OUT, pcALUop, P_out,
                  BrEQ, BrLt, preg_write, pImmSel, BSeL, ASeL, BrUN, MemRw, WBSeL};

  localparam logic [31:0] ObsPc = 32'h0000_0017;  // AUIPC x0,0 -> P_out = PC

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural state of the reference model
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [64];

  typedef struct packed {
    logic [98:0] obs;
    logic [31:0] next_pc;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        st;
    logic [5:0]  saddr;
    logic [31:0] sdata;
  } exp_t;

  function automatic logic [31:0] obs_reg(input logic [4:0] k);
    return {12'b0, k, 3'b0, 5'b0, 7'h33};  // ADD x0,xk,x0 -> P_out = xk
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] code, input logic [31:0] a,
                                          input logic [31:0] b);
    case (code)
      4'h0: return a + b;
      4'h8: return a - b;
      4'h1: return a << b[4:0];
      4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3: return (a < b) ? 32'd1 : 32'd0;
      4'h4: return a ^ b;
      4'h5: return a >> b[4:0];
      4'hD: return $unsigned($signed(a) >>> b[4:0]);
      4'h6: return a | b;
      4'h7: return a & b;
      4'hF: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] rs1v, rs2v, a, b, imm, i_imm, res, ld, pout, npc;
    logic [3:0]  code;
    logic [2:0]  f3;
    logic legal, regw, immsel, bsel, asel, brun, memrw, wbsel, jump, taken, breq, brlt;
    f3    = ins[14:12];
    rs1v  = m_regs[ins[19:15]];
    rs2v  = m_regs[ins[24:20]];
    i_imm = {{20{ins[31]}}, ins[31:20]};
    {legal, regw, immsel, bsel, asel, brun, memrw, wbsel, jump} = 9'b1_0000_0000;
    code = 4'h0;
    imm  = 32'd0;
    a    = rs1v;
    case (ins[6:0])
      7'h33: begin regw = 1; code = {ins[30], f3}; end
      7'h13: begin
        {regw, immsel, bsel} = 3'b111;
        imm  = i_imm;
        code = (f3 == 3'd5 && ins[30]) ? 4'hD : {1'b0, f3};
      end
      7'h03: begin {regw, immsel, bsel, wbsel} = 4'b1111; imm = i_imm; end
      7'h23: begin
        {immsel, bsel, memrw} = 3'b111;
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'h63: begin
        {immsel, bsel, asel} = 3'b111;
        imm  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        brun = (f3 >= 3'd6);
        a    = m_pc;
      end
      7'h37: begin {regw, immsel, bsel} = 3'b111; imm = {ins[31:12], 12'h0}; code = 4'hF; end
      7'h17: begin {regw, immsel, bsel, asel} = 4'b1111; imm = {ins[31:12], 12'h0}; a = m_pc; end
      7'h6F: begin
        {regw, immsel, bsel, asel, jump} = 5'b11111;
        imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        a   = m_pc;
      end
      7'h67: begin {regw, immsel, bsel, jump} = 4'b1111; imm = i_imm; end
      default: legal = 0;
    endcase
    b    = bsel ? imm : rs2v;
    res  = alu_ref(code, a, b);
    breq = legal && (rs1v == rs2v);
    brlt = legal && (brun ? (rs1v < rs2v) : ($signed(rs1v) < $signed(rs2v)));
    taken = 0;
    if (ins[6:0] == 7'h63) begin
      case (f3)
        3'd0: taken = (rs1v == rs2v);
        3'd1: taken = (rs1v != rs2v);
        3'd4: taken = ($signed(rs1v) < $signed(rs2v));
        3'd5: taken = ($signed(rs1v) >= $signed(rs2v));
        3'd6: taken = (rs1v < rs2v);
        3'd7: taken = (rs1v >= rs2v);
        default: taken = 0;
      endcase
    end
    ld = 32'd0;
`ifdef PROCESSOR_DMEM_EN
    ld = m_mem[res[7:2]];
`endif
    pout = jump ? m_pc + 32'd4 : (wbsel ? ld : res);
    if (ins[6:0] == 7'h6F)      npc = m_pc + imm;
    else if (ins[6:0] == 7'h67) npc = (rs1v + imm) & ~32'd1;
    else if (taken)             npc = m_pc + imm;
    else                        npc = m_pc + 32'd4;
    e         = '0;
    e.obs     = {ins[6:0], ins[19:15], ins[24:20], ins[11:7], imm, code, pout,
                 breq, brlt, regw, immsel, bsel, asel, brun, memrw, wbsel};
    e.next_pc = npc;
    e.wr      = regw;
    e.rd      = ins[11:7];
    e.wdata   = pout;
`ifdef PROCESSOR_DMEM_EN
    e.st      = memrw;
`endif
    e.saddr   = res[7:2];
    e.sdata   = rs2v;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
  endtask

  task automatic drive(input logic [31:0] ins, input logic tog, output exp_t e);
    @(negedge clk);
    Instr  = ins;
    toggle = tog;
    #1;
    e = model(ins);
  endtask

  task automatic commit(input exp_t e);
    @(posedge clk);
    if (rst_n && toggle) begin
      if (e.wr && e.rd != 5'd0) m_regs[e.rd] = e.wdata;
      if (e.st) m_mem[e.saddr] = e.sdata;
      m_pc = e.next_pc;
    end
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    #3;
    n_checks++;
    if (w_obs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", w_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0, 1'b1, e);
    n_checks++;
    if (w_obs !== '0) begin
      n_fail++; $display("FAIL instr0_outputs: got %h required 0", w_obs);
    end
    commit(e);
    drive(ObsPc, 1'b0, e);
    n_checks++;
    if (P_out !== 32'd4) begin
      n_fail++; $display("FAIL pc_after_instr0: got %h required 4", P_out);
    end
    for (int k = 1; k < 32; k++) begin
      drive(obs_reg(5'(k)), 1'b0, e);
      n_checks++;
      if (P_out !== 32'd0) begin
        n_fail++; $display("FAIL reg_after_reset x%0d: got %h required 0", k, P_out);
      end
    end
  endtask

  task automatic test_alu_basic();
    exp_t e;
    drive(32'h0050_0093, 1'b1, e);
    n_checks++;
    if ({pcrd, pcImm_OUT, BSeL, preg_write, P_out} !== {5'd1, 32'd5, 1'b1, 1'b1, 32'd5}) begin
      n_fail++;
      $display("FAIL addi: got rd=%0d imm=%h bsel=%b we=%b pout=%h required 1,5,1,1,5",
               pcrd, pcImm_OUT, BSeL, preg_write, P_out);
    end
    commit(e);
    drive(32'h0010_8133, 1'b1, e);
    n_checks++;
    if ({pcALUop, P_out} !== {4'b0000, 32'd10}) begin
      n_fail++; $display("FAIL add: got op=%b pout=%h required 0000,0000000a", pcALUop, P_out);
    end
    commit(e);
  endtask

  task automatic test_store_load();
    exp_t        e;
    logic [31:0] ld_exp;
`ifdef PROCESSOR_DMEM_EN
    ld_exp = 32'd5;
`else
    ld_exp = 32'd0;
`endif
    drive(32'h0010_2023, 1'b1, e);
    n_checks++;
    if ({MemRw, pImmSel, preg_write} !== 3'b110) begin
      n_fail++; $display("FAIL sw_ctrl: got %b required 110", {MemRw, pImmSel, preg_write});
    end
    commit(e);
    drive(32'h0000_2183, 1'b1, e);
    n_checks++;
    if ({WBSeL, P_out} !== {1'b1, ld_exp}) begin
      n_fail++; $display("FAIL lw: got wbsel=%b pout=%h required 1,%h", WBSeL, P_out, ld_exp);
    end
    commit(e);
  endtask

  task automatic test_branch();
    exp_t        e;
    logic [31:0] p;
    p = m_pc;
    drive(32'h0000_0463, 1'b1, e);
    n_checks++;
    if ({BrEQ, ASeL, pcImm_OUT} !== {1'b1, 1'b1, 32'd8}) begin
      n_fail++; $display("FAIL beq_ctrl: got breq=%b asel=%b imm=%h required 1,1,8",
                         BrEQ, ASeL, pcImm_OUT);
    end
    commit(e);
    drive(ObsPc, 1'b0, e);
    n_checks++;
    if (P_out !== p + 32'd8) begin
      n_fail++; $display("FAIL beq_target: got %h required %h", P_out, p + 32'd8);
    end
  endtask

  task automatic test_toggle_hold();
    exp_t        e;
    logic [31:0] p;
    drive(32'h0070_0093, 1'b1, e);
    commit(e);
    p = m_pc;
    repeat (3) begin
      drive(32'h0050_0093, 1'b0, e);
      commit(e);
    end
    drive(obs_reg(5'd1), 1'b0, e);
    n_checks++;
    if (P_out !== 32'd7) begin
      n_fail++; $display("FAIL hold_x1: got %h required 7", P_out);
    end
    drive(ObsPc, 1'b0, e);
    n_checks++;
    if (P_out !== p) begin
      n_fail++; $display("FAIL hold_pc: got %h required %h", P_out, p);
    end
  endtask

  task automatic test_illegal_sweep();
    exp_t e;
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < 10; c++) begin
        drive(32'(k * 4), 1'b1, e);
        n_checks++;
        if ({pcImm_OUT, pcALUop, BrEQ, BrLt, preg_write, pImmSel, BSeL, ASeL, BrUN, MemRw,
             WBSeL} !== '0) begin
          n_fail++; $display("FAIL illegal_ctrl instr=%h: got imm=%h op=%b strobes nonzero",
                             Instr, pcImm_OUT, pcALUop);
        end
        if (k == 5 && c == 5) begin
          rst_n  = 1'b0;
          Instr  = ObsPc;
          toggle = 1'b0;
          #1;
          n_checks++;
          if (P_out !== 32'd0) begin
            n_fail++; $display("FAIL async_reset_pc: got %h required 0", P_out);
          end
          Instr = obs_reg(5'd1);
          #1;
          n_checks++;
          if (P_out !== 32'd0) begin
            n_fail++; $display("FAIL async_reset_x1: got %h required 0", P_out);
          end
          Instr = 32'h0000_2003;  // LW x0,0(x0)
          #1;
          n_checks++;
          if (P_out !== 32'd0) begin
            n_fail++; $display("FAIL async_reset_mem: got %h required 0", P_out);
          end
          model_reset();
          @(negedge clk);
          rst_n = 1'b1;
        end else begin
          commit(e);
        end
      end
      drive(ObsPc, 1'b0, e);
      n_checks++;
      if (P_out !== m_pc) begin
        n_fail++; $display("FAIL sweep_pc step %0d: got %h required %h", k, P_out, m_pc);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] i12;
    logic [12:0] b13;
    r   = $urandom;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    i12 = r[11:0];
    b13 = r[12:0];
    case ($urandom_range(0, 10))
      0: return {1'b0, (f3 == 3'd0 || f3 == 3'd5) ? r[20] : 1'b0, 5'b0, rs2, rs1, f3, rd, 7'h33};
      1, 2: begin
        if (f3 == 3'd1 || f3 == 3'd5) i12[11:5] = {1'b0, r[25], 5'b0};
        return {i12, rs1, f3, rd, 7'h13};
      end
      3: return {i12, rs1, 3'b010, rd, 7'h03};
      4: return {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23};
      5: begin
        if (f3 == 3'd2 || f3 == 3'd3) f3 = f3 + 3'd2;
        return {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], 7'h63};
      end
      6: return {r[31:12], rd, 7'h37};
      7: return {r[31:12], rd, 7'h17};
      8: return {r[31:12], rd, 7'h6F};
      9: return {i12, rs1, 3'b000, rd, 7'h67};
      default: return {r[31:7], 7'h0B};
    endcase
  endfunction

  task automatic test_random();
    exp_t        e;
    logic [31:0] ins;
    for (int n = 0; n < 400; n++) begin
      ins = rand_instr();
      drive(ins, ($urandom_range(0, 3) != 0), e);
      n_checks++;
      if (w_obs !== e.obs) begin
        n_fail++;
        $display("FAIL random[%0d] instr=%h: got %h required %h", n, ins, w_obs, e.obs);
      end
      commit(e);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    toggle = 1'b0;
    Instr  = 32'h0;
    model_reset();
    test_reset();
    test_alu_basic();
    test_store_load();
    test_branch();
    test_toggle_hold();
    test_illegal_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
